vdp_line_scaler: RTL and testbench

//  Upstream video stage: stores VDP pixel lines in a ping-pong line buffer and

---
 rtl/vdp_scaler_pkg.sv | 15 +
 rtl/line_buffer_ram.sv | 24 ++
 rtl/vdp_line_scaler.sv | 111 +++++++++++
 tb/tb_vdp_line_scaler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_scaler_pkg.sv
// Shared types and width helpers for the VDP line scaler.
package vdp_scaler_pkg;

    typedef logic [23:0] rgb24_t;

    localparam rgb24_t BORDER_RGB_DEF = 24'h0;
    localparam int     SRC_WIDTH_DEF  = 512;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_w(SRC_WIDTH_DEF);

endpackage

// File: rtl/line_buffer_ram.sv
// Ping-pong line store: one write port, one registered read port, address {bank, idx}.
module line_buffer_ram
    import vdp_scaler_pkg::*;
#(
    parameter int ADDR_W = IDX_W_DEF + 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  rgb24_t            wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output rgb24_t            rd_data
);

    rgb24_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vdp_line_scaler.sv
// Buffers VDP lines in a ping-pong RAM and returns the colour for each HDMI (cx, cy),
// with integer replication, a border fill and a fixed two-cycle latency.
module vdp_line_scaler
    import vdp_scaler_pkg::*;
#(
    parameter int     SRC_WIDTH  = 512,
    parameter int     SRC_HEIGHT = 240,
    parameter int     X_OFFSET   = 40,
    parameter int     Y_OFFSET   = 0,
    parameter int     H_SHIFT    = 0,
    parameter int     V_SHIFT    = 1,
    parameter rgb24_t BORDER_RGB = BORDER_RGB_DEF
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        vdp_line_start,
    input  logic        vdp_pixel_valid,
    input  rgb24_t      vdp_rgb,
    input  logic [11:0] cx,
    input  logic [10:0] cy,
    output rgb24_t      rgb,
    output logic        line_overflow
);

    localparam int               IDX_W   = idx_w(SRC_WIDTH);
    localparam int               CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] SRC_W_C = CNT_W'(SRC_WIDTH);
    localparam logic [12:0]      X_OFF   = 13'(X_OFFSET);
    localparam logic [11:0]      Y_OFF   = 12'(Y_OFFSET);
    localparam logic [12:0]      WIN_W   = 13'(SRC_WIDTH << H_SHIFT);
    localparam logic [11:0]      WIN_H   = 12'(SRC_HEIGHT << V_SHIFT);
    localparam logic [11:0]      V_MASK  = 12'((1 << V_SHIFT) - 1);

    logic                       wr_bank;
    logic [CNT_W-1:0]           wr_idx;
    logic [1:0][CNT_W-1:0]      count;
    logic                       wr_en;
    logic [IDX_W:0]             wr_addr;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = {wr_bank, wr_idx[IDX_W-1:0]};
        if (vdp_line_start) begin
            // A pixel coinciding with line_start belongs to the new line.
            wr_en   = vdp_pixel_valid;
            wr_addr = {~wr_bank, {IDX_W{1'b0}}};
        end else if (vdp_pixel_valid && (wr_idx < SRC_W_C)) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank       <= 1'b0;
            wr_idx        <= '0;
            count         <= '0;
            line_overflow <= 1'b0;
        end else begin
            line_overflow <= vdp_pixel_valid && !vdp_line_start && (wr_idx == SRC_W_C);
            if (vdp_line_start) begin
                count[wr_bank] <= wr_idx;
                wr_bank        <= ~wr_bank;
                wr_idx         <= vdp_pixel_valid ? CNT_W'(1) : '0;
            end else if (wr_en) begin
                wr_idx <= wr_idx + CNT_W'(1);
            end
        end
    end

    logic [12:0]      dx;
    logic [11:0]      dy;
    logic             in_win;
    logic [IDX_W-1:0] src_x;
    logic             rd_bank;
    logic             rd_bank_eff;
    logic             valid_q;
    rgb24_t           ram_q;

    always_comb begin
        dx     = {1'b0, cx} - X_OFF;
        dy     = {1'b0, cy} - Y_OFF;
        in_win = !dx[12] && (dx < WIN_W) && !dy[11] && (dy < WIN_H);
        src_x  = IDX_W'(dx >> H_SHIFT);
        // Bank only swaps at the start of a raster line that begins a new source line.
        rd_bank_eff = ((cx == 12'd0) && ((dy & V_MASK) == 12'd0)) ? ~wr_bank : rd_bank;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            rd_bank <= 1'b1;
            valid_q <= 1'b0;
            rgb     <= '0;
        end else begin
            rd_bank <= rd_bank_eff;
            valid_q <= in_win && ({1'b0, src_x} < count[rd_bank_eff]);
            rgb     <= valid_q ? ram_q : BORDER_RGB;
        end
    end

    line_buffer_ram #(
        .ADDR_W (IDX_W + 1)
    ) u_ram (
        .clk     (clk_pixel),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (vdp_rgb),
        .rd_addr ({rd_bank_eff, src_x}),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_vdp_line_scaler.sv
// Directed bench for vdp_line_scaler: a default instance and an H_SHIFT=1 instance
// share all inputs, so every written line is checked under both replications.
module tb_vdp_line_scaler;
    import vdp_scaler_pkg::*;

    logic        clk_pixel = 1'b0;
    logic        reset_n = 1'b0;
    logic        vdp_line_start = 1'b0;
    logic        vdp_pixel_valid = 1'b0;
    rgb24_t      vdp_rgb = '0;
    logic [11:0] cx = '0;
    logic [10:0] cy = '0;
    rgb24_t      rgb, rgb_h;
    logic        line_overflow, line_overflow_h;

    int n_pass = 0;
    int n_total = 0;
    int ovf_cnt = 0;

    always #5 clk_pixel = ~clk_pixel;

    vdp_line_scaler u_dut (
        .clk_pixel       (clk_pixel),
        .reset_n         (reset_n),
        .vdp_line_start  (vdp_line_start),
        .vdp_pixel_valid (vdp_pixel_valid),
        .vdp_rgb         (vdp_rgb),
        .cx              (cx),
        .cy              (cy),
        .rgb             (rgb),
        .line_overflow   (line_overflow)
    );

    vdp_line_scaler #(.H_SHIFT(1)) u_dut_h (
        .clk_pixel       (clk_pixel),
        .reset_n         (reset_n),
        .vdp_line_start  (vdp_line_start),
        .vdp_pixel_valid (vdp_pixel_valid),
        .vdp_rgb         (vdp_rgb),
        .cx              (cx),
        .cy              (cy),
        .rgb             (rgb_h),
        .line_overflow   (line_overflow_h)
    );

    always @(negedge clk_pixel) if (line_overflow) ovf_cnt <= ovf_cnt + 1;

    typedef struct {
        int     x;
        int     y;
        rgb24_t exp;
        rgb24_t exp_h;
    } vec_t;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic write_line(input rgb24_t base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_pixel);
            vdp_pixel_valid = 1'b1;
            vdp_rgb = base + 24'(i);
        end
        @(negedge clk_pixel);
        vdp_pixel_valid = 1'b0;
    endtask

    task automatic line_start();
        @(negedge clk_pixel);
        vdp_line_start = 1'b1;
        @(negedge clk_pixel);
        vdp_line_start = 1'b0;
    endtask

    task automatic rd(input int x, input int y, output rgb24_t q, output rgb24_t qh);
        @(negedge clk_pixel);
        cx = 12'(x);
        cy = 11'(y);
        repeat (2) @(negedge clk_pixel);
        q  = rgb;
        qh = rgb_h;
    endtask

    function automatic rgb24_t ramp_main(input int c);
        return (c >= 40 && c < 552) ? 24'(c - 40) : 24'h0;
    endfunction

    function automatic rgb24_t ramp_h(input int c);
        return (c >= 40 && c < 1064) ? 24'((c - 40) >> 1) : 24'h0;
    endfunction

    vec_t   vecs[12];
    rgb24_t q, qh;
    int     ovf0;

    initial begin
        vecs[0]  = '{0,    0,    24'd0,   24'd0};
        vecs[1]  = '{39,   0,    24'd0,   24'd0};
        vecs[2]  = '{40,   0,    24'd0,   24'd0};
        vecs[3]  = '{41,   0,    24'd1,   24'd0};
        vecs[4]  = '{42,   0,    24'd2,   24'd1};
        vecs[5]  = '{551,  0,    24'd511, 24'd255};
        vecs[6]  = '{552,  0,    24'd0,   24'd256};
        vecs[7]  = '{1063, 0,    24'd0,   24'd511};
        vecs[8]  = '{1064, 0,    24'd0,   24'd0};
        vecs[9]  = '{100,  479,  24'd60,  24'd30};
        vecs[10] = '{100,  480,  24'd0,   24'd0};
        vecs[11] = '{4095, 2047, 24'd0,   24'd0};

        // Reset, start a line, then reset again in the middle of it.
        repeat (3) @(negedge clk_pixel);
        reset_n = 1'b1;
        line_start();
        write_line(24'hFFFFFF, 10);
        @(negedge clk_pixel);
        vdp_pixel_valid = 1'b1;
        reset_n = 1'b0;
        @(negedge clk_pixel);
        vdp_pixel_valid = 1'b0;
        check("reset_rgb", rgb, 24'h0);
        check("reset_rgb_h", rgb_h, 24'h0);
        check("reset_ovf", {23'd0, line_overflow}, 24'h0);
        @(negedge clk_pixel);
        reset_n = 1'b1;

        // Ramp line of exactly SRC_WIDTH pixels, then a full pipelined sweep.
        ovf0 = ovf_cnt;
        write_line(24'h0, 512);
        line_start();
        repeat (2) @(negedge clk_pixel);
        check("ovf_none_at_512", 24'(ovf_cnt - ovf0), 24'd0);
        cy = 11'd0;
        for (int c = 0; c <= 1072; c++) begin
            @(negedge clk_pixel);
            if (c >= 2) begin
                check($sformatf("sweep cx=%0d", c - 2), rgb, ramp_main(c - 2));
                check($sformatf("sweep_h cx=%0d", c - 2), rgb_h, ramp_h(c - 2));
            end
            cx = 12'(c);
        end

        for (int i = 0; i < 12; i++) begin
            rd(vecs[i].x, vecs[i].y, q, qh);
            check($sformatf("vec%0d cx=%0d cy=%0d", i, vecs[i].x, vecs[i].y), q, vecs[i].exp);
            check($sformatf("vec%0d_h cx=%0d cy=%0d", i, vecs[i].x, vecs[i].y), qh, vecs[i].exp_h);
        end

        // Short line: count boundary.
        write_line(24'h100000, 100);
        line_start();
        rd(0, 0, q, qh);
        check("short_cx0", q, 24'h0);
        rd(139, 0, q, qh);
        check("short_dx99", q, 24'h100063);
        check("short_dx99_h", qh, 24'h100031);
        rd(140, 0, q, qh);
        check("short_dx100", q, 24'h0);
        check("short_dx100_h", qh, 24'h100032);

        // Overlong line: three dropped pixels.
        ovf0 = ovf_cnt;
        write_line(24'h200000, 515);
        repeat (3) @(negedge clk_pixel);
        check("ovf_pulses", 24'(ovf_cnt - ovf0), 24'd3);
        line_start();
        rd(0, 0, q, qh);
        rd(551, 0, q, qh);
        check("ovf_entry511", q, 24'h2001FF);
        rd(40, 0, q, qh);
        check("ovf_entry0", q, 24'h200000);
        rd(552, 0, q, qh);
        check("ovf_past_end", q, 24'h0);

        // Vertical replication and no mid-line bank swap.
        rd(0, 0, q, qh);
        rd(50, 0, q, qh);
        check("vrep_cy0", q, 24'h20000A);
        rd(0, 1, q, qh);
        rd(50, 1, q, qh);
        check("vrep_cy1", q, 24'h20000A);
        @(negedge clk_pixel);
        cx = 12'd300;
        cy = 11'd1;
        write_line(24'h300000, 20);
        line_start();
        rd(50, 1, q, qh);
        check("no_tear_cy1", q, 24'h20000A);
        rd(0, 2, q, qh);
        rd(50, 2, q, qh);
        check("swap_cy2", q, 24'h30000A);
        rd(59, 2, q, qh);
        check("swap_last", q, 24'h300013);
        rd(60, 2, q, qh);
        check("swap_past_count", q, 24'h0);

        // line_start and pixel_valid together.
        write_line(24'h400000, 5);
        @(negedge clk_pixel);
        vdp_line_start = 1'b1;
        vdp_pixel_valid = 1'b1;
        vdp_rgb = 24'hABCDEF;
        @(negedge clk_pixel);
        vdp_line_start = 1'b0;
        vdp_pixel_valid = 1'b0;
        rd(0, 4, q, qh);
        rd(44, 4, q, qh);
        check("prev_bank_last", q, 24'h400004);
        rd(45, 4, q, qh);
        check("prev_bank_count", q, 24'h0);
        write_line(24'h500001, 2);
        line_start();
        rd(0, 6, q, qh);
        rd(40, 6, q, qh);
        check("same_cycle_px0", q, 24'hABCDEF);
        check("same_cycle_px0_h", qh, 24'hABCDEF);
        rd(41, 6, q, qh);
        check("same_cycle_px1", q, 24'h500001);
        check("hrep_dx1", qh, 24'hABCDEF);
        rd(42, 6, q, qh);
        check("same_cycle_px2", q, 24'h500002);
        check("hrep_dx2", qh, 24'h500001);
        rd(43, 6, q, qh);
        check("same_cycle_end", q, 24'h0);
        rd(45, 6, q, qh);
        check("hrep_dx5", qh, 24'h500002);
        rd(46, 6, q, qh);
        check("hrep_dx6", qh, 24'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
